// File: rtl/coke_pkg.sv
// Shared definitions for the coin-operated vending controller.
// Holds the default price, the credit-width helper and the state names
// used by the default three-coin build for readable waveforms.
package coke_pkg;

    // Coins needed for one coke unless the instance overrides it.
    localparam int unsigned DEFAULT_PRICE = 3;

    // The credit counter runs 0..price-1. It is always at least one bit wide,
    // so PRICE=1 still has a register (permanently 0).
    function automatic int unsigned credit_width(input int unsigned price);
        int unsigned w;
        w = $clog2(price);
        return (w < 1) ? 1 : w;
    endfunction

    // Named credit values for the default PRICE=3 build.
    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no coins held
        ONE  = 2'd1,  // one coin held
        TWO  = 2'd2   // two coins held, next coin buys a coke
    } coke_state_e;

endpackage

// File: rtl/coke_fsm.sv
// Vending controller: counts coin strobes and emits a one-cycle registered
// dispense pulse on the edge that samples the PRICE-th coin, clearing the
// credit at the same time. Coins landing while the pulse is high already
// count toward the next purchase.
module coke_fsm
    import coke_pkg::*;
#(
    parameter int unsigned PRICE = DEFAULT_PRICE
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic pay,
    output logic coke
);

    localparam int unsigned     CW   = credit_width(PRICE);
    localparam logic [CW-1:0]   LAST = CW'(PRICE - 1);

    logic [CW-1:0] r_credit;
    logic          r_coke;
    logic [CW-1:0] w_credit_next;
    logic          w_coke_next;

    generate
        if (PRICE == 3) begin : g_named
            // Default build: the credit is decoded into named states so the
            // waveform reads IDLE/ONE/TWO. The encoding equals the coin count.
            coke_state_e w_state;
            coke_state_e w_state_next;

            assign w_state = coke_state_e'(r_credit);

            // Next state and dispense decision; the unused encoding 3 can only
            // come from an upset and falls back to IDLE without dispensing.
            always_comb begin
                w_state_next = IDLE;
                w_coke_next  = 1'b0;
                case (w_state)
                    IDLE: w_state_next = pay ? ONE : IDLE;
                    ONE:  w_state_next = pay ? TWO : ONE;
                    TWO: begin
                        if (pay) begin
                            w_state_next = IDLE;
                            w_coke_next  = 1'b1;
                        end else begin
                            w_state_next = TWO;
                        end
                    end
                    default: w_state_next = IDLE;
                endcase
            end

            assign w_credit_next = w_state_next;
        end else begin : g_generic
            // Any other price: plain modulo-PRICE coin counter. A value past
            // LAST can only come from an upset and is cleared without a coke.
            always_comb begin
                w_credit_next = r_credit;
                w_coke_next   = 1'b0;
                if (r_credit > LAST) begin
                    w_credit_next = '0;
                end else if (pay) begin
                    if (r_credit == LAST) begin
                        w_credit_next = '0;
                        w_coke_next   = 1'b1;
                    end else begin
                        w_credit_next = r_credit + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Credit and dispense registers; reset clears both without waiting for a clock.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_credit <= '0;
            r_coke   <= 1'b0;
        end else begin
            r_credit <= w_credit_next;
            r_coke   <= w_coke_next;
        end
    end

    assign coke = r_coke;

endmodule

// File: tb/tb_coke_fsm.sv
// Directed and random bench for coke_fsm at PRICE=3, 1 and 5, all three
// instances sharing clock, reset and coin strobe.
module tb_coke_fsm;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic pay     = 1'b0;
    logic coke3, coke1, coke5;

    int checks   = 0;
    int failures = 0;

    // Reference credits for each instance.
    int c3 = 0;
    int c1 = 0;
    int c5 = 0;

    // Pulse and coin tallies for the random phase.
    int coins  = 0;
    int p3_cnt = 0;
    int p1_cnt = 0;
    int p5_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    coke_fsm #(.PRICE(3)) dut3 (.sys_clk(sys_clk), .sys_rst(sys_rst), .pay(pay), .coke(coke3));
    coke_fsm #(.PRICE(1)) dut1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .pay(pay), .coke(coke1));
    coke_fsm #(.PRICE(5)) dut5 (.sys_clk(sys_clk), .sys_rst(sys_rst), .pay(pay), .coke(coke5));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the reference credit for one edge; returns the expected coke.
    function automatic logic model_step(inout int c, input int price, input logic p);
        if (!p) return 1'b0;
        if (c == price - 1) begin
            c = 0;
            return 1'b1;
        end
        c = c + 1;
        return 1'b0;
    endfunction

    // One clock with coin strobe p. exp3 is the hand-computed PRICE=3 result,
    // or -1 to take it from the reference model. Entered and left 1 ns after
    // a rising edge.
    task automatic step(input string tag, input logic p, input int exp3);
        logic e3, e1, e5;
        pay = p;
        e3 = model_step(c3, 3, p);
        e1 = model_step(c1, 1, p);
        e5 = model_step(c5, 5, p);
        if (exp3 >= 0) e3 = exp3[0];
        @(posedge sys_clk);
        #1;
        chk({tag, "_coke3"}, {7'd0, coke3}, {7'd0, e3});
        chk({tag, "_coke1"}, {7'd0, coke1}, {7'd0, e1});
        chk({tag, "_coke5"}, {7'd0, coke5}, {7'd0, e5});
        $display("step %s pay=%0b coke3=%0b coke1=%0b coke5=%0b", tag, p, coke3, coke1, coke5);
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic async_reset(input string tag);
        #2;
        sys_rst = 1'b1;
        #1;
        chk({tag, "_rst_coke3"}, {7'd0, coke3}, 8'd0);
        chk({tag, "_rst_coke5"}, {7'd0, coke5}, 8'd0);
        chk({tag, "_rst_credit3"}, 8'(dut3.r_credit), 8'd0);
        c3 = 0; c1 = 0; c5 = 0;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        $display("reset %s applied and released", tag);
    endtask

    initial begin
        // Reset held 50 ns with pay toggling: outputs and credit stay 0.
        for (int i = 0; i < 10; i++) begin
            #5;
            pay = ~pay;
            chk("hold_rst_coke3", {7'd0, coke3}, 8'd0);
            chk("hold_rst_coke1", {7'd0, coke1}, 8'd0);
            chk("hold_rst_credit3", 8'(dut3.r_credit), 8'd0);
        end
        @(posedge sys_clk);
        #1;
        pay = 1'b0;
        sys_rst = 1'b0;

        // After release nothing happens until three coins are in.
        step("idle0", 1'b0, 0);
        step("idle1", 1'b0, 0);
        step("buy_a", 1'b1, 0);
        chk("credit_one", 8'(dut3.r_credit), 8'd1);
        step("buy_b", 1'b1, 0);
        chk("credit_two", 8'(dut3.r_credit), 8'd2);
        step("buy_c", 1'b1, 1);
        chk("credit_clear", 8'(dut3.r_credit), 8'd0);
        step("buy_end", 1'b0, 0);

        // Sparse coins: 1,0,0,1,0,1 buys once, on the sixth edge.
        step("sparse1", 1'b1, 0);
        step("sparse2", 1'b0, 0);
        step("sparse3", 1'b0, 0);
        chk("sparse_hold", 8'(dut3.r_credit), 8'd1);
        step("sparse4", 1'b1, 0);
        step("sparse5", 1'b0, 0);
        step("sparse6", 1'b1, 1);
        step("sparse_end", 1'b0, 0);

        // pay held high for 9 cycles: 0,0,1 repeating.
        for (int i = 0; i < 9; i++) begin
            step("hold_pay", 1'b1, (i % 3 == 2) ? 1 : 0);
        end
        step("hold_end", 1'b0, 0);

        // Reset mid-purchase discards the two coins already in.
        step("mid1", 1'b1, 0);
        step("mid2", 1'b1, 0);
        async_reset("mid");
        step("post1", 1'b1, 0);
        step("post_gap", 1'b0, 0);
        step("post2", 1'b1, 0);
        step("post3", 1'b1, 1);
        step("post_end", 1'b0, 0);

        // Reset in the coke-high cycle drops the pulse immediately.
        step("hi1", 1'b1, 0);
        step("hi2", 1'b1, 0);
        step("hi3", 1'b1, 1);
        async_reset("hi");
        step("hi_after", 1'b0, 0);

        // Random coins against the reference models, credit starting at 0.
        c3 = 0; c1 = 0; c5 = 0;
        async_reset("rand");
        for (int i = 0; i < 1000; i++) begin
            logic p;
            p = 1'($urandom_range(0, 1));
            if (p) coins++;
            step("rand", p, -1);
            if (coke3) p3_cnt++;
            if (coke1) p1_cnt++;
            if (coke5) p5_cnt++;
        end
        chk("rand_pulses3", 8'(p3_cnt - coins / 3), 8'd0);
        chk("rand_pulses1", 8'(p1_cnt - coins), 8'd0);
        chk("rand_pulses5", 8'(p5_cnt - coins / 5), 8'd0);
        $display("random coins=%0d pulses3=%0d pulses1=%0d pulses5=%0d", coins, p3_cnt, p1_cnt, p5_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
